// File: rtl/sip_dot_pkg.sv
// Shared widths, saturation bounds and multiply-mode encoding for the slice dot-product pipeline.
package sip_dot_pkg;

  typedef struct packed {
    logic bin;
    logic sign_w;
    logic sign_i;
  } mode_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  function automatic int bits_mul(input int p);
    return 2 * p + 1;
  endfunction

  function automatic int bits_sum(input int p, input int n);
    return bits_mul(p) + clog2(n);
  endfunction

  function automatic longint acc_max(input int b);
    return (longint'(1) << (b - 1)) - 1;
  endfunction

  function automatic longint acc_min(input int b);
    return -(longint'(1) << (b - 1));
  endfunction

endpackage

// File: rtl/sip_mul_lane.sv
// One dot-product lane: sign/zero-extends both slices and multiplies, or returns +/-1 in XNOR mode.
// Purely combinational; the caller registers the product.
module sip_mul_lane
  import sip_dot_pkg::*;
#(
  parameter int BITS_PAR = 2,
  localparam int BITS_MUL = bits_mul(BITS_PAR)
) (
  input  logic [BITS_PAR-1:0]        a_i,
  input  logic [BITS_PAR-1:0]        w_i,
  input  mode_t                      mode_i,
  output logic signed [BITS_MUL-1:0] prod_o
);

  logic signed [BITS_MUL-1:0] a_ext;
  logic signed [BITS_MUL-1:0] w_ext;

  // Extending to BITS_MUL before multiplying keeps the full product range in-width.
  always_comb begin
    a_ext = {{(BITS_MUL - BITS_PAR){mode_i.sign_i & a_i[BITS_PAR-1]}}, a_i};
    w_ext = {{(BITS_MUL - BITS_PAR){mode_i.sign_w & w_i[BITS_PAR-1]}}, w_i};
    if (mode_i.bin) begin
      prod_o = (a_i[0] == w_i[0]) ? BITS_MUL'(1) : '1;
    end else begin
      prod_o = a_ext * w_ext;
    end
  end

endmodule

// File: rtl/sip_dot_acc_pipe.sv
// Pipelined slice dot product with shifted, saturating multi-beat accumulation.
// Last beat accepted at t gives a result at t+3; every stage stalls while a result waits unconsumed.
module sip_dot_acc_pipe
  import sip_dot_pkg::*;
#(
  parameter int N_DOT      = 32,
  parameter int BITS_PAR   = 2,
  parameter int BITS_SHIFT = 4,
  parameter int BITS_ACC   = 24
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  input  logic [N_DOT*BITS_PAR-1:0] i_Act,
  input  logic [N_DOT*BITS_PAR-1:0] i_Weight,
  input  logic                      i_SignI,
  input  logic                      i_SignW,
  input  logic                      i_Bin,
  input  logic [BITS_SHIFT-1:0]     i_Shift,
  input  logic                      i_First,
  input  logic                      i_Last,
  output logic                      o_Valid,
  input  logic                      i_Ready,
  output logic [BITS_ACC-1:0]       o_Acc,
  output logic                      o_Sat
);

  localparam int BITS_MUL = bits_mul(BITS_PAR);
  localparam int BITS_SUM = bits_sum(BITS_PAR, N_DOT);
  localparam int BITS_SHF = BITS_ACC + BITS_SHIFT;
  localparam int BITS_TOT = BITS_SHF + 1;
  localparam logic signed [BITS_TOT-1:0] ACC_MAX = BITS_TOT'(acc_max(BITS_ACC));
  localparam logic signed [BITS_TOT-1:0] ACC_MIN = BITS_TOT'(acc_min(BITS_ACC));

  typedef struct packed {
    logic                  vld;
    logic                  first;
    logic                  last;
    logic [BITS_SHIFT-1:0] shift;
  } side_t;

  mode_t                      mode;
  logic signed [BITS_MUL-1:0] prod [N_DOT];
  logic signed [BITS_MUL-1:0] s1_prod_q [N_DOT];
  side_t                      s1_q, s2_q;
  logic signed [BITS_SUM-1:0] sum_d, s2_sum_q;
  logic signed [BITS_SHF-1:0] shifted;
  logic signed [BITS_TOT-1:0] base, total;
  logic signed [BITS_ACC-1:0] acc_d, acc_q, out_acc_q;
  logic                       sat_d, sat_q, out_sat_q, out_vld_q;
  logic                       open_d, open_q, start, clamp, adv;

  assign mode    = '{bin: i_Bin, sign_w: i_SignW, sign_i: i_SignI};
  assign adv     = ~(out_vld_q & ~i_Ready);
  assign o_Ready = adv;
  assign o_Valid = out_vld_q;
  assign o_Acc   = out_acc_q;
  assign o_Sat   = out_sat_q;

  for (genvar k = 0; k < N_DOT; k++) begin : g_lane
    sip_mul_lane #(.BITS_PAR(BITS_PAR)) u_lane (
      .a_i    (i_Act[BITS_PAR*k +: BITS_PAR]),
      .w_i    (i_Weight[BITS_PAR*k +: BITS_PAR]),
      .mode_i (mode),
      .prod_o (prod[k])
    );
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (adv) begin
      s1_q <= '{vld: i_Valid, first: i_First, last: i_Last, shift: i_Shift};
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (adv) begin
      s1_prod_q <= prod;
      s2_sum_q  <= sum_d;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_DOT; k++) begin
      sum_d = sum_d + BITS_SUM'(s1_prod_q[k]);
    end
  end

  // A group restarts on First or on any beat following a Last (or reset).
  always_comb begin
    start   = s2_q.first | ~open_q;
    shifted = BITS_SHF'(s2_sum_q) <<< s2_q.shift;
    base    = start ? '0 : BITS_TOT'(acc_q);
    total   = BITS_TOT'(shifted) + base;
    clamp   = 1'b0;
    acc_d   = total[BITS_ACC-1:0];
    if (total > ACC_MAX) begin
      acc_d = ACC_MAX[BITS_ACC-1:0];
      clamp = 1'b1;
    end else if (total < ACC_MIN) begin
      acc_d = ACC_MIN[BITS_ACC-1:0];
      clamp = 1'b1;
    end
    sat_d  = (sat_q & ~start) | clamp;
    open_d = ~s2_q.last;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      open_q    <= 1'b0;
      out_vld_q <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      if (adv && s2_q.vld) begin
        acc_q  <= acc_d;
        sat_q  <= sat_d;
        open_q <= open_d;
      end
      if (adv && s2_q.vld && s2_q.last) begin
        out_vld_q <= 1'b1;
        out_acc_q <= acc_d;
        out_sat_q <= sat_d;
      end else if (out_vld_q && i_Ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule
